bayer_mosaic: RTL
=================

BAYER_MOSAIC -- requirements
Module: bayer_mosaic

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, maximum image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 512, maximum image height in pixels.
REQ-003 SHALL have parameter IMG_SIZE, default WIDTH*HEIGHT, channel/bayer memory depth in pixels.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_en, input, 1, one-cycle start pulse; samples height/width.
REQ-007 SHALL have ports height and width, input, 11 each, image dimensions in pixels.
REQ-008 SHALL have ports rd_r/rd_g/rd_b, output, 1 each, read strobes to R/G/B channel memories.
REQ-009 SHALL have ports addr_r/addr_g/addr_b, output, 19 each, read addresses; inactive channel address held 0.
REQ-010 SHALL have ports rdata_r/rdata_g/rdata_b, input, 8 each, combinational read data for same-cycle address.
REQ-011 SHALL have ports wr_bayer (1), addr_bayer (19), wdata_bayer (8), outputs, bayer memory write.
REQ-012 SHALL have ports busy and done, output, 1 each, status.

Function
REQ-013 SHALL use states IDLE, RUN, FLUSH, DONE; IDLE->RUN on in_en with valid size, IDLE->DONE on in_en with invalid size.
REQ-014 SHALL treat size as invalid when height==0, width==0, width>WIDTH, height>HEIGHT, or height*width>IMG_SIZE.
REQ-015 SHALL in RUN read one pixel per cycle in raster order, index = row*width+col, starting at index 0.
REQ-016 SHALL select RGGB colour: even row/even col R, even row/odd col G, odd row/even col G, odd row/odd col B; exactly one rd_x high per RUN cycle.
REQ-017 SHALL register the selected rdata and index, asserting wr_bayer with addr_bayer=index exactly 1 cycle after the read.
REQ-018 SHALL wrap col to 0 and increment row when col==width-1; RUN->FLUSH after reading index height*width-1.
REQ-019 SHALL in FLUSH issue the final write, then enter DONE; total in_en-to-done latency = height*width+2 cycles.
REQ-020 SHALL hold done high in DONE until next in_en, which restarts (DONE->RUN or DONE->DONE) and clears done the following cycle.
REQ-021 SHALL hold busy high in RUN and FLUSH only; in_en while busy SHALL be ignored.
REQ-022 SHALL compute indices in 19-bit unsigned arithmetic, size product in 22 bits; no write outside [0, height*width-1].
REQ-023 SHALL drive wr_bayer, rd_r/g/b low outside RUN/FLUSH; no write ever repeated or skipped.

Reset
REQ-024 SHALL on reset: state IDLE; busy, done, wr_bayer, rd_r/g/b 0; all addresses and wdata_bayer 0; counters 0.
REQ-025 SHALL abort any transfer on reset mid-operation with no further writes after reset asserts.

Configuration
REQ-026 SHALL, with MOSAIC_CHECKSUM_EN defined, add output checksum (16 bits) = sum mod 2^16 of all wdata_bayer written this frame, cleared on in_en, valid while done high.
REQ-027 SHALL, without MOSAIC_CHECKSUM_EN, have no checksum port or logic; all other behaviour identical.

Structure
REQ-028 SHALL place in mosaic_pkg: ADDR_W=19, PIX_W=8, DIM_W=11, colour enum {CH_R, CH_G, CH_B}, state enum.
REQ-029 SHALL instantiate one sub-module bayer_cfa_sel mapping (row[0], col[0]) to colour enum.

Verification
REQ-030 SHALL cover 4x4 frame, R=10+i, G=100+i, B=200+i at index i -> bayer[0]=10, [1]=101, [4]=104, [5]=205; done at cycle 18 after in_en.
REQ-031 SHALL cover width=0, height=8 -> no rd/wr pulses, done high 1 cycle after in_en.
REQ-032 SHALL cover 1024x512 frame -> 524288 writes, last addr_bayer=524287, colour B, no address beyond.
REQ-033 SHALL cover reset asserted at read index 7 of 4x4 frame -> wr_bayer low at once, done 0, restart yields full correct frame.
REQ-034 SHALL cover in_en pulsed during RUN of 3x3 frame -> ignored, exactly 9 writes, single done.
REQ-035 SHALL cover, with MOSAIC_CHECKSUM_EN, 2x2 frame with all channels 255 -> checksum 1020 when done.

Source files
------------

// File: rtl/bayer_mosaic_pkg.sv
// ---------------------------------------------------------------------------
// mosaic_pkg : shared widths, colour and state encodings for bayer_mosaic
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mosaic_pkg;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;
  localparam int DIM_W  = 11;
  localparam int PROD_W = 22;

  typedef enum logic [1:0] {CH_R, CH_G, CH_B} colour_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

`default_nettype wire

// File: rtl/bayer_mosaic_if.sv
// ---------------------------------------------------------------------------
// bayer_mosaic_if : control, channel-read and bayer-write bundle
// Optional MOSAIC_CHECKSUM_EN adds the checksum signal.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bayer_mosaic_if;
  import mosaic_pkg::*;

  logic              in_en;
  logic [DIM_W-1:0]  height;
  logic [DIM_W-1:0]  width;
  logic              rd_r, rd_g, rd_b;
  logic [ADDR_W-1:0] addr_r, addr_g, addr_b;
  logic [PIX_W-1:0]  rdata_r, rdata_g, rdata_b;
  logic              wr_bayer;
  logic [ADDR_W-1:0] addr_bayer;
  logic [PIX_W-1:0]  wdata_bayer;
  logic              busy;
  logic              done;
`ifdef MOSAIC_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  modport master (
    output in_en, height, width, rdata_r, rdata_g, rdata_b,
    input
`ifdef MOSAIC_CHECKSUM_EN
          checksum,
`endif
          rd_r, rd_g, rd_b, addr_r, addr_g, addr_b,
          wr_bayer, addr_bayer, wdata_bayer, busy, done
  );

  modport slave (
    input  in_en, height, width, rdata_r, rdata_g, rdata_b,
    output
`ifdef MOSAIC_CHECKSUM_EN
           checksum,
`endif
           rd_r, rd_g, rd_b, addr_r, addr_g, addr_b,
           wr_bayer, addr_bayer, wdata_bayer, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/bayer_cfa_sel.sv
// ---------------------------------------------------------------------------
// bayer_cfa_sel : RGGB colour filter lookup from row/column parity
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bayer_cfa_sel
  import mosaic_pkg::*;
(
  input  logic    row_lsb,
  input  logic    col_lsb,
  output colour_t colour
);
  always_comb begin
    case ({row_lsb, col_lsb})
      2'b00:   colour = CH_R;
      2'b11:   colour = CH_B;
      default: colour = CH_G;
    endcase
  end
endmodule

`default_nettype wire

// File: rtl/bayer_mosaic.sv
// ---------------------------------------------------------------------------
// bayer_mosaic : raster-scans R/G/B planes and writes an RGGB mosaic frame
// Optional MOSAIC_CHECKSUM_EN adds a per-frame write checksum. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bayer_mosaic
  import mosaic_pkg::*;
#(
  parameter int WIDTH    = 1024,
  parameter int HEIGHT   = 512,
  parameter int IMG_SIZE = WIDTH * HEIGHT
) (
  input  logic          clk,
  input  logic          reset,
  bayer_mosaic_if.slave bus
);
  localparam logic [31:0] MAX_W  = 32'(WIDTH);
  localparam logic [31:0] MAX_H  = 32'(HEIGHT);
  localparam logic [31:0] MAX_SZ = 32'(IMG_SIZE);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d, col_q, col_d;
  logic              row_odd_q, row_odd_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d, waddr_q, waddr_d;
  logic [PIX_W-1:0]  wdata_q, wdata_d, rdata_sel;
  logic              wr_q, wr_d;
  logic              size_ok, running;
  logic [PROD_W-1:0] size_prod;
  colour_t           colour;

  bayer_cfa_sel u_cfa_sel (
    .row_lsb (row_odd_q),
    .col_lsb (col_q[0]),
    .colour  (colour)
  );

  assign size_prod = PROD_W'(bus.height) * PROD_W'(bus.width);
  assign size_ok   = (bus.height != '0) && (bus.width != '0)
                  && (32'(bus.width) <= MAX_W) && (32'(bus.height) <= MAX_H)
                  && (32'(size_prod) <= MAX_SZ);
  assign running   = (state_q == RUN);

  always_comb begin
    case (colour)
      CH_R:    rdata_sel = bus.rdata_r;
      CH_G:    rdata_sel = bus.rdata_g;
      default: rdata_sel = bus.rdata_b;
    endcase
  end

  // Only the channel being read drives a non-zero address.
  assign bus.rd_r   = running && (colour == CH_R);
  assign bus.rd_g   = running && (colour == CH_G);
  assign bus.rd_b   = running && (colour == CH_B);
  assign bus.addr_r = bus.rd_r ? idx_q : '0;
  assign bus.addr_g = bus.rd_g ? idx_q : '0;
  assign bus.addr_b = bus.rd_b ? idx_q : '0;

  assign bus.wr_bayer    = wr_q;
  assign bus.addr_bayer  = waddr_q;
  assign bus.wdata_bayer = wdata_q;
  assign bus.busy        = running || (state_q == FLUSH);
  assign bus.done        = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    last_d    = last_q;
    col_d     = col_q;
    row_odd_d = row_odd_q;
    idx_d     = idx_q;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.in_en) begin
          if (size_ok) begin
            state_d   = RUN;
            width_d   = bus.width;
            last_d    = ADDR_W'(size_prod - PROD_W'(1));
            col_d     = '0;
            row_odd_d = 1'b0;
            idx_d     = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        wr_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = rdata_sel;
        if (idx_q == last_q) begin
          state_d = FLUSH;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
          if (col_q == width_q - DIM_W'(1)) begin
            col_d     = '0;
            row_odd_d = ~row_odd_q;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      width_q   <= '0;
      last_q    <= '0;
      col_q     <= '0;
      row_odd_q <= 1'b0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      last_q    <= last_d;
      col_q     <= col_d;
      row_odd_q <= row_odd_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef MOSAIC_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // An accepted start never coincides with a pending write, so clear wins.
  always_comb begin
    csum_d = csum_q;
    if (bus.in_en && !bus.busy) begin
      csum_d = '0;
    end else if (wr_q) begin
      csum_d = csum_q + 16'(wdata_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.checksum = csum_q;
`endif
endmodule

`default_nettype wire
